ftoi_pipe: RTL and testbench

//   Pipelined single-precision float -> signed 32-bit integer converter; inverse of the FPU's itof unit.

---
 rtl/fpu_pkg.sv | 29 ++
 rtl/ftoi_decode.sv | 42 ++++
 rtl/ftoi_pipe.sv | 92 +++++++++
 tb/tb_ftoi_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types and constants for the float <-> integer conversion units.
package fpu_pkg;

  localparam int FP_BIAS  = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // -2^31 is the only E=31 value that fits exactly in a signed 32-bit integer.
  localparam logic [31:0] FP_NEG_2P31 = 32'hCF00_0000;

  typedef struct packed {
    logic                s;
    logic [FP_EXP_W-1:0] e;
    logic [FP_MAN_W-1:0] m;
  } fp32_t;

  typedef struct packed {
    logic [31:0] mag;
    logic        guard;
    logic        sticky;
    logic        sign;
    logic        sat;
    logic        nan;
  } ftoi_s1_t;

endpackage

// File: rtl/ftoi_decode.sv
// Stage-1 logic of the float -> int converter: classifies the operand and
// aligns the mantissa into an integer magnitude plus guard/sticky bits.
module ftoi_decode
  import fpu_pkg::*;
(
  input  fp32_t    x_i,
  output ftoi_s1_t dec_o
);

  logic signed [8:0] exp_unb;
  logic        [5:0] sh_amt;
  logic       [54:0] shifted;

  assign exp_unb = $signed({1'b0, x_i.e}) - 9'sd127;

  // The 55-bit window places the binary point between bits 24 and 23 after
  // the shift, so bits [54:24] are the integer part and bit 23 is the guard.
  always_comb begin
    dec_o      = '0;
    dec_o.sign = x_i.s;
    sh_amt     = '0;
    shifted    = '0;
    if ((x_i.e == 8'hFF) && (x_i.m != '0)) begin
      dec_o.nan = 1'b1;
    end else if (exp_unb >= 9'sd31) begin
      if (x_i == fp32_t'(FP_NEG_2P31)) begin
        dec_o.mag = INT_MIN;
      end else begin
        dec_o.sat = 1'b1;
      end
    end else if (exp_unb <= -9'sd2) begin
      dec_o.sticky = |{x_i.e, x_i.m};
    end else begin
      sh_amt       = 6'(9'sd30 - exp_unb);
      shifted      = {1'b1, x_i.m, 31'b0} >> sh_amt;
      dec_o.mag    = {1'b0, shifted[54:24]};
      dec_o.guard  = shifted[23];
      dec_o.sticky = |shifted[22:0];
    end
  end

endmodule

// File: rtl/ftoi_pipe.sv
// Two-stage pipelined binary32 -> signed int32 converter with valid/ready
// handshake on both sides and saturation of out-of-range operands.
module ftoi_pipe
  import fpu_pkg::*;
#(
  parameter int          ROUND_MODE = 0,
  parameter logic [31:0] NAN_RESULT = 32'h7FFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf
);

  fp32_t    x_fp;
  ftoi_s1_t dec;
  logic     unused_sticky;

  logic        s1_valid_q, s2_valid_q;
  logic [31:0] s1_mag_q;
  logic        s1_guard_q, s1_sign_q, s1_sat_q, s1_nan_q;
  logic [31:0] y_q, y_d;
  logic        ovf_q, ovf_d;
  logic [31:0] rounded_mag, signed_val;
  logic        adv1, adv2;

  assign x_fp = fp32_t'(x);

  ftoi_decode u_decode (
    .x_i  (x_fp),
    .dec_o(dec)
  );

  // Rounding is ties-away, so only the guard bit matters.
  assign unused_sticky = dec.sticky;

  assign adv2     = ~s2_valid_q | out_ready;
  assign adv1     = ~s1_valid_q | adv2;
  assign in_ready = adv1;

  assign rounded_mag = (ROUND_MODE == 0) ? s1_mag_q + {31'b0, s1_guard_q} : s1_mag_q;
  assign signed_val  = s1_sign_q ? (~rounded_mag + 32'd1) : rounded_mag;

  always_comb begin
    y_d   = signed_val;
    ovf_d = 1'b0;
    if (s1_nan_q) begin
      y_d   = NAN_RESULT;
      ovf_d = 1'b1;
    end else if (s1_sat_q) begin
      y_d   = s1_sign_q ? INT_MIN : INT_MAX;
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (adv1) s1_valid_q <= in_valid;
      if (adv2) s2_valid_q <= s1_valid_q;
      if (adv2 && s1_valid_q) begin
        y_q   <= y_d;
        ovf_q <= ovf_d;
      end
    end
  end

  // Stage-1 payload needs no reset: it is only consumed under s1_valid_q.
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      s1_mag_q   <= dec.mag;
      s1_guard_q <= dec.guard;
      s1_sign_q  <= dec.sign;
      s1_sat_q   <= dec.sat;
      s1_nan_q   <= dec.nan;
    end
  end

  assign out_valid = s2_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ftoi_pipe.sv
// Self-checking bench for ftoi_pipe: both rounding modes side by side,
// directed vectors, a stalled stream, reset mid-flight and a real-valued sweep.
module tb_ftoi_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic        outReady;
  logic [31:0] xIn;
  logic        inReady0, inReady1, outValid0, outValid1, ovf0, ovf1;
  logic [31:0] y0, y1;

  int compareCount  = 0;
  int mismatchCount = 0;

  always #5 clk = ~clk;

  ftoi_pipe #(.ROUND_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady0), .x(xIn),
    .out_valid(outValid0), .out_ready(outReady), .y(y0), .ovf(ovf0)
  );

  ftoi_pipe #(.ROUND_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady1), .x(xIn),
    .out_valid(outValid1), .out_ready(outReady), .y(y1), .ovf(ovf1)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] yNear;
    logic        ovfNear;
    logic [31:0] yTrunc;
    logic        ovfTrunc;
  } vec_t;

  localparam int NUM_VECS = 22;
  vec_t vecs [NUM_VECS];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Sends one operand into an otherwise idle pipeline and collects both results.
  task automatic applyStimulus(input logic [31:0] xv,
                               output logic [31:0] r0, output logic o0,
                               output logic [31:0] r1, output logic o1,
                               output logic earlyValid, output int lat);
    @(negedge clk);
    xIn      = xv;
    inValid  = 1'b1;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    inValid    = 1'b0;
    earlyValid = outValid0 | outValid1;
    lat        = 0;
    while (!(outValid0 && outValid1) && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r0 = y0;
    o0 = ovf0;
    r1 = y1;
    o1 = ovf1;
  endtask

  function automatic void modelFtoi(input logic [31:0] xv, input int mode,
                                    output logic [31:0] yv, output logic ov);
    logic [7:0]  e;
    logic [22:0] m;
    real         f, p;
    int          r;
    e  = xv[30:23];
    m  = xv[22:0];
    yv = 32'h0;
    ov = 1'b0;
    if (e == 8'hFF) begin
      ov = 1'b1;
      yv = (m != 0) ? 32'h7FFF_FFFF : (xv[31] ? 32'h8000_0000 : 32'h7FFF_FFFF);
    end else if (e != 8'h00) begin
      p = 1.0;
      if (e >= 150) begin
        for (int i = 0; i < int'(e) - 150; i++) p = p * 2.0;
      end else begin
        for (int i = 0; i < 150 - int'(e); i++) p = p / 2.0;
      end
      f = (8388608.0 + real'(m)) * p;
      if (f >= 2147483648.0) begin
        if (xv[31] && f == 2147483648.0) begin
          yv = 32'h8000_0000;
        end else begin
          ov = 1'b1;
          yv = xv[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
      end else begin
        r  = (mode == 0) ? $rtoi(f + 0.5) : $rtoi(f);
        yv = xv[31] ? 32'(-r) : 32'(r);
      end
    end
  endfunction

  initial begin
    logic [31:0] r0, r1, ey0, ey1, mv;
    logic        o0, o1, eo0, eo1, early;
    int          lat, sent, recv, seenValid;
    logic [22:0] mList [5];

    vecs[0]  = '{32'h3FC0_0000, 32'd2,          1'b0, 32'd1,          1'b0};
    vecs[1]  = '{32'hC020_0000, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1};
    vecs[3]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0};
    vecs[4]  = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 32'h7FFF_FF80, 1'b0};
    vecs[5]  = '{32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1};
    vecs[6]  = '{32'hFF80_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1};
    vecs[7]  = '{32'h0000_0001, 32'd0,          1'b0, 32'd0,          1'b0};
    vecs[8]  = '{32'h8000_0000, 32'd0,          1'b0, 32'd0,          1'b0};
    vecs[9]  = '{32'h3F00_0000, 32'd1,          1'b0, 32'd0,          1'b0};
    vecs[10] = '{32'h3F80_0000, 32'd1,          1'b0, 32'd1,          1'b0};
    vecs[11] = '{32'hBF00_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,          1'b0};
    vecs[12] = '{32'h3EFF_FFFF, 32'd0,          1'b0, 32'd0,          1'b0};
    vecs[13] = '{32'h3F7F_FFFF, 32'd1,          1'b0, 32'd0,          1'b0};
    vecs[14] = '{32'hCF00_0001, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1};
    vecs[15] = '{32'h42F7_0000, 32'd124,        1'b0, 32'd123,        1'b0};
    vecs[16] = '{32'hC2F7_0000, 32'hFFFF_FF84, 1'b0, 32'hFFFF_FF85, 1'b0};
    vecs[17] = '{32'h4B00_0001, 32'h0080_0001, 1'b0, 32'h0080_0001, 1'b0};
    vecs[18] = '{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1};
    vecs[19] = '{32'hFFC0_0001, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1};
    vecs[20] = '{32'h3FE0_0000, 32'd2,          1'b0, 32'd1,          1'b0};
    vecs[21] = '{32'h4010_0000, 32'd2,          1'b0, 32'd2,          1'b0};

    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    xIn      = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("reset out_valid", {31'b0, outValid0}, 32'd0);
    checkOutput("reset y", y0, 32'd0);
    checkOutput("reset ovf", {31'b0, ovf0}, 32'd0);
    checkOutput("reset in_ready", {31'b0, inReady0}, 32'd1);

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].x, r0, o0, r1, o1, early, lat);
      checkOutput($sformatf("vec%0d early out_valid", i), {31'b0, early}, 32'd0);
      checkOutput($sformatf("vec%0d latency", i), lat, 32'd1);
      checkOutput($sformatf("vec%0d y near", i), r0, vecs[i].yNear);
      checkOutput($sformatf("vec%0d ovf near", i), {31'b0, o0}, {31'b0, vecs[i].ovfNear});
      checkOutput($sformatf("vec%0d y trunc", i), r1, vecs[i].yTrunc);
      checkOutput($sformatf("vec%0d ovf trunc", i), {31'b0, o1}, {31'b0, vecs[i].ovfTrunc});
    end

    // Drain the last result before streaming.
    @(negedge clk);
    outReady = 1'b1;
    repeat (3) @(posedge clk);

    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 40 && recv < 10; cyc++) begin
      @(negedge clk);
      inValid  = (sent < 10);
      xIn      = vecs[(sent < 10) ? sent : 0].x;
      outReady = !(cyc >= 3 && cyc <= 5);
      #1;
      if (cyc >= 3 && cyc <= 5) begin
        checkOutput($sformatf("stream c%0d in_ready", cyc), {31'b0, inReady0}, 32'd0);
        checkOutput($sformatf("stream c%0d out_valid", cyc), {31'b0, outValid0}, 32'd1);
        checkOutput($sformatf("stream c%0d held y", cyc), y0, vecs[1].yNear);
      end
      if (outValid0 && outReady) begin
        checkOutput($sformatf("stream r%0d y near", recv), y0, vecs[recv].yNear);
        checkOutput($sformatf("stream r%0d y trunc", recv), y1, vecs[recv].yTrunc);
        checkOutput($sformatf("stream r%0d ovf", recv), {31'b0, ovf0}, {31'b0, vecs[recv].ovfNear});
        recv++;
      end
      if (inValid && inReady0) sent++;
    end
    checkOutput("stream sent", sent, 32'd10);
    checkOutput("stream received", recv, 32'd10);

    @(negedge clk);
    inValid  = 1'b0;
    outReady = 1'b1;
    repeat (3) @(posedge clk);

    @(negedge clk);
    outReady = 1'b0;
    inValid  = 1'b1;
    xIn      = vecs[0].x;
    @(negedge clk);
    xIn      = vecs[1].x;
    @(negedge clk);
    inValid = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midreset out_valid", {31'b0, outValid0}, 32'd0);
    checkOutput("midreset y", y0, 32'd0);
    checkOutput("midreset ovf", {31'b0, ovf0}, 32'd0);
    checkOutput("midreset in_ready", {31'b0, inReady0}, 32'd1);
    @(negedge clk);
    outReady  = 1'b1;
    seenValid = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (outValid0 || outValid1) seenValid++;
    end
    checkOutput("midreset stale results", seenValid, 32'd0);

    mList[0] = 23'h000000;
    mList[1] = 23'h000001;
    mList[2] = 23'h400000;
    mList[3] = 23'h7FFFFF;
    for (int s = 0; s < 2; s++) begin
      for (int e = 0; e < 256; e++) begin
        mList[4] = 23'($urandom);
        for (int k = 0; k < 5; k++) begin
          mv = {1'(s), 8'(e), mList[k]};
          modelFtoi(mv, 0, ey0, eo0);
          modelFtoi(mv, 1, ey1, eo1);
          applyStimulus(mv, r0, o0, r1, o1, early, lat);
          checkOutput($sformatf("sweep %h latency", mv), lat, 32'd1);
          checkOutput($sformatf("sweep %h y near", mv), r0, ey0);
          checkOutput($sformatf("sweep %h ovf near", mv), {31'b0, o0}, {31'b0, eo0});
          checkOutput($sformatf("sweep %h y trunc", mv), r1, ey1);
          checkOutput($sformatf("sweep %h ovf trunc", mv), {31'b0, o1}, {31'b0, eo1});
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
